imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, is the memory word-index width (64 words).
REQ-002 Parameter MAX_WAIT, default 4, is the number of consecutive loader grants allowed while a fetch waits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 f_req  input  1  fetch read request; held with stable f_addr until f_gnt.
REQ-006 f_addr  input  32  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  f_rdata/f_err valid this cycle.
REQ-009 f_rdata  output  32  read instruction word.
REQ-010 f_err  output  1  misaligned fetch flag, qualified by f_rvalid.
REQ-011 l_req  input  1  loader write request; held with stable l_addr/l_wdata until l_gnt.
REQ-012 l_addr  input  32  loader byte address.
REQ-013 l_wdata  input  32  loader write data.
REQ-014 l_gnt  output  1  loader request accepted this cycle.
REQ-015 l_err  output  1  one-cycle pulse with l_gnt when l_addr[1:0] != 0.
REQ-016 mem_en  output  1  memory port enable.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  ADDR_W  word index = granted addr[ADDR_W+1:2].
REQ-019 mem_wdata  output  32  write data to memory.
REQ-020 mem_rdata  input  32  synchronous read data, valid the cycle after a read enable.

Function
REQ-021 At most one of f_gnt, l_gnt shall be high in any cycle; grants are combinational from the current requests and state.
REQ-022 Default priority: loader; when f_req and l_req are both high and wait_cnt < MAX_WAIT, l_gnt=1.
REQ-023 When f_req and l_req are both high and wait_cnt == MAX_WAIT, f_gnt=1.
REQ-024 A lone request is granted in the same cycle.
REQ-025 wait_cnt (width clog2(MAX_WAIT+1)) shall increment on l_gnt while f_req=1, clear on f_gnt or when f_req=0, and saturate at MAX_WAIT.
REQ-026 On f_gnt: mem_en=1, mem_we=0, mem_addr from f_addr.
REQ-027 On l_gnt with aligned l_addr: mem_en=1, mem_we=1, mem_addr from l_addr, mem_wdata=l_wdata.
REQ-028 On l_gnt with misaligned l_addr: mem_en=0 (write dropped) and l_err=1.
REQ-029 With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 f_rvalid shall be high exactly one cycle after each f_gnt (latency 1); f_rdata=mem_rdata when f_rvalid=1, else 0.
REQ-031 f_err shall equal the registered f_addr[1:0] != 0 of the granted fetch, asserted with f_rvalid.
REQ-032 A misaligned fetch shall still read the word at addr[ADDR_W+1:2].
REQ-033 Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^(ADDR_W+2).
REQ-034 Back-to-back fetch grants yield back-to-back f_rvalid pulses, one per grant, in order.
REQ-035 busy-free design: no request shall wait more than MAX_WAIT+1 cycles while held.

Reset
REQ-036 While reset=1: f_gnt, l_gnt, f_rvalid, f_err, l_err, mem_en, mem_we = 0; mem_addr, mem_wdata, f_rdata = 0; wait_cnt = 0.
REQ-037 Reset asserted the cycle after an f_gnt shall suppress that f_rvalid.
REQ-038 The first grant may occur in the first cycle after reset deasserts.

Verification
REQ-039 Lone fetch: f_req=1, f_addr=0x10 -> f_gnt and mem_addr=4 that cycle; next cycle f_rvalid=1, f_rdata=mem_rdata, f_err=0.
REQ-040 Contention, MAX_WAIT=4: f_req and l_req held high -> l_gnt for 4 cycles, f_gnt on cycle 5, then l_gnt resumes with wait_cnt=0.
REQ-041 Loader write: l_req=1, l_addr=0x2C, l_wdata=0x00948663 -> mem_en=1, mem_we=1, mem_addr=11, mem_wdata=0x00948663.
REQ-042 Misaligned: l_addr=0x0E -> l_gnt=1, l_err=1, mem_en=0; fetch f_addr=0x0E -> mem_addr=3, f_rvalid with f_err=1.
REQ-043 Wrap: f_addr=0x100 with ADDR_W=6 -> mem_addr=0.
REQ-044 Reset mid-read: f_gnt at cycle N, reset=1 at N+1 -> f_rvalid=0 at N+1, all outputs 0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter in front of a single-port instruction memory: a fetch reader and a
// loader writer share the port. The loader wins by default, and a fetch is starvation-bounded.
module imem_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int MAX_WAIT = 4,
  localparam int CNT_W = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  wait_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  // Handshake: a requester holds req (and its address/data) stable until its gnt is high
  // in the same cycle; gnt is combinational, so the transfer happens in that cycle.
  logic fetch_turn;
  logic l_aligned;
  logic l_write;
  logic rvalid_q;
  logic ferr_q;

  assign fetch_turn = (wait_cnt == MAX_CNT);
  assign f_gnt      = ~reset & f_req & (~l_req | fetch_turn);
  assign l_gnt      = ~reset & l_req & ~(f_req & fetch_turn);
  assign l_aligned  = (l_addr[1:0] == 2'b00);
  assign l_write    = l_gnt & l_aligned;
  assign l_err      = l_gnt & ~l_aligned;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = f_addr[ADDR_W+1:2];
    end else if (l_write) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = l_addr[ADDR_W+1:2];
      mem_wdata = l_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rvalid_q <= f_gnt;
      ferr_q   <= f_gnt & (f_addr[1:0] != 2'b00);
      if (f_gnt || !f_req) begin
        wait_cnt <= '0;
      end else if (l_gnt && !fetch_turn) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // The read response is masked during reset so a reset right after a grant kills it.
  assign f_rvalid = rvalid_q & ~reset;
  assign f_err    = ferr_q & ~reset;
  assign f_rdata  = f_rvalid ? mem_rdata : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus a randomized run checked against
// an event-level model of arbitration and of the memory image.
module tb_imem_port_arbiter;
  localparam int ADDR_W = 6;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam int WORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              f_req = 1'b0;
  logic [31:0]       f_addr = '0;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;
  logic              l_req = 1'b0;
  logic [31:0]       l_addr = '0;
  logic [31:0]       l_wdata = '0;
  logic              l_gnt;
  logic              l_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic [CNT_W-1:0]  wait_cnt;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] mem [WORDS];
  logic [31:0] shadow [WORDS];
  logic [32:0] exp_q[$];

  imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .wait_cnt(wait_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // synchronous single-port memory behind the arbiter
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic [31:0] la, input logic [31:0] ld);
    f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = ld;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_reset();
    logic [121:0] outs;
    drive(1'b1, 32'h10, 1'b1, 32'h20, 32'hdead_beef);
    @(negedge clk);
    outs = {f_gnt, l_gnt, f_rvalid, f_err, l_err, mem_en, mem_we, mem_addr, mem_wdata,
            f_rdata, 16'(wait_cnt), 10'h0};
    n_tests++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    drive(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    n_tests++;
    if ({f_gnt, l_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 6'd4}) begin
      n_fail++;
      $display("FAIL lone_fetch_gnt: got %b expected %b",
               {f_gnt, l_gnt, mem_en, mem_we, mem_addr}, {4'b1010, 6'd4});
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({f_rvalid, f_err, f_rdata} !== {2'b10, shadow[4]}) begin
      n_fail++;
      $display("FAIL lone_fetch_rsp: got %h expected %h", {f_rvalid, f_err, f_rdata},
               {2'b10, shadow[4]});
    end
    tick();
  endtask

  task automatic test_loader_write();
    drive(1'b0, 32'h0, 1'b1, 32'h2C, 32'h0094_8663);
    @(negedge clk);
    n_tests++;
    if ({l_gnt, l_err, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 6'd11, 32'h0094_8663}) begin
      n_fail++;
      $display("FAIL loader_write: got %h expected %h", {l_gnt, l_err, mem_en, mem_we, mem_addr,
               mem_wdata}, {4'b1011, 6'd11, 32'h0094_8663});
    end
    shadow[11] = 32'h0094_8663;
    tick();
    drive(1'b1, 32'h2C, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({f_rvalid, f_rdata} !== {1'b1, 32'h0094_8663}) begin
      n_fail++;
      $display("FAIL loader_readback: got %h expected %h", {f_rvalid, f_rdata}, {1'b1, 32'h0094_8663});
    end
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b0, 32'h0, 1'b1, 32'h0E, 32'hffff_0000);
    @(negedge clk);
    n_tests++;
    if ({l_gnt, l_err, mem_en, mem_we} !== 4'b1100) begin
      n_fail++; $display("FAIL misaligned_write: got %b expected 1100", {l_gnt, l_err, mem_en, mem_we});
    end
    tick();
    drive(1'b1, 32'h0E, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({f_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 6'd3}) begin
      n_fail++;
      $display("FAIL misaligned_fetch_addr: got %b expected %b", {f_gnt, mem_en, mem_we, mem_addr},
               {3'b110, 6'd3});
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({f_rvalid, f_err, f_rdata} !== {2'b11, shadow[3]}) begin
      n_fail++;
      $display("FAIL misaligned_fetch_rsp: got %h expected %h", {f_rvalid, f_err, f_rdata},
               {2'b11, shadow[3]});
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] addrs [2];
    logic [ADDR_W-1:0] exp_idx [2];
    addrs[0] = 32'h100;      exp_idx[0] = 6'd0;
    addrs[1] = 32'hffff_fffc; exp_idx[1] = 6'd63;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, addrs[i], 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      n_tests++;
      if ({f_gnt, mem_addr} !== {1'b1, exp_idx[i]}) begin
        n_fail++;
        $display("FAIL wrap_addr_%0d: got %h expected %h", i, {f_gnt, mem_addr}, {1'b1, exp_idx[i]});
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] d;
    d = $urandom;
    drive(1'b1, 32'h20, 1'b1, 32'h30, d);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_tests++;
      if ({f_gnt, l_gnt, wait_cnt} !== {c == 5, c != 5, CNT_W'(c == 6 ? 0 : c - 1)}) begin
        n_fail++;
        $display("FAIL contention_cycle_%0d: got %b expected %b", c, {f_gnt, l_gnt, wait_cnt},
                 {c == 5, c != 5, CNT_W'(c == 6 ? 0 : c - 1)});
      end
      if (c == 6) begin
        n_tests++;
        if ({f_rvalid, f_rdata} !== {1'b1, shadow[8]}) begin
          n_fail++;
          $display("FAIL contention_rsp: got %h expected %h", {f_rvalid, f_rdata}, {1'b1, shadow[8]});
        end
      end
      tick();
    end
    shadow[12] = d;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [121:0] outs;
    drive(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if (f_gnt !== 1'b1) begin
      n_fail++; $display("FAIL mid_read_gnt: got %b expected 1", f_gnt);
    end
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h8, 1'b1, 32'h10, 32'h1234_5678);
    @(negedge clk);
    outs = {f_gnt, l_gnt, f_rvalid, f_err, l_err, mem_en, mem_we, mem_addr, mem_wdata,
            f_rdata, 16'(wait_cnt), 10'h0};
    n_tests++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL mid_read_reset: got %h expected 0", outs);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if (f_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_read_after: got %b expected 0", f_rvalid);
    end
    tick();
  endtask

  task automatic test_random(input int n);
    int waited = 0;
    int f_held = 0;
    logic efg, elg, ewr, exp_rv;
    logic [32:0] exp_rd;
    logic [ADDR_W-1:0] ea;
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      if (!f_req && $urandom_range(0, 2) != 0) begin f_req = 1'b1; f_addr = rand_addr(); end
      if (!l_req && $urandom_range(0, 2) != 0) begin
        l_req = 1'b1; l_addr = rand_addr(); l_wdata = $urandom;
      end
      efg = f_req && (!l_req || waited == MAX_WAIT);
      elg = l_req && !efg;
      ewr = elg && (l_addr[1:0] == 2'b00);
      ea = efg ? f_addr[ADDR_W+1:2] : (ewr ? l_addr[ADDR_W+1:2] : '0);
      exp_rv = exp_q.size() > 0;
      exp_rd = exp_rv ? exp_q.pop_front() : 33'h0;
      @(negedge clk);
      n_tests++;
      if ({f_gnt, l_gnt, l_err} !== {efg, elg, elg && !ewr}) begin
        n_fail++;
        $display("FAIL rand_gnt c%0d: got %b expected %b", c, {f_gnt, l_gnt, l_err},
                 {efg, elg, elg && !ewr});
      end
      n_tests++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {efg || ewr, ewr, ea, ewr ? l_wdata : 32'h0}) begin
        n_fail++;
        $display("FAIL rand_mem c%0d: got %h expected %h", c, {mem_en, mem_we, mem_addr, mem_wdata},
                 {efg || ewr, ewr, ea, ewr ? l_wdata : 32'h0});
      end
      n_tests++;
      if ({f_rvalid, f_err, f_rdata} !== {exp_rv, exp_rd}) begin
        n_fail++;
        $display("FAIL rand_rsp c%0d: got %h expected %h", c, {f_rvalid, f_err, f_rdata},
                 {exp_rv, exp_rd});
      end
      n_tests++;
      if (wait_cnt !== CNT_W'(waited)) begin
        n_fail++; $display("FAIL rand_wait_cnt c%0d: got %0d expected %0d", c, wait_cnt, waited);
      end
      if (f_req) f_held++;
      if (efg) begin
        n_tests++;
        if (f_held > MAX_WAIT + 1) begin
          n_fail++; $display("FAIL rand_starve c%0d: got %0d expected <= %0d", c, f_held, MAX_WAIT + 1);
        end
        f_held = 0;
        exp_q.push_back({f_addr[1:0] != 2'b00, shadow[f_addr[ADDR_W+1:2]]});
      end
      if (ewr) shadow[l_addr[ADDR_W+1:2]] = l_wdata;
      if (efg || !f_req) waited = 0;
      else if (elg && waited < MAX_WAIT) waited++;
      tick();
      if (efg) f_req = 1'b0;
      if (elg) l_req = 1'b0;
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      shadow[i] = $urandom;
      mem[i] = shadow[i];
    end
    tick();
    tick();
    test_reset();
    test_lone_fetch();
    test_loader_write();
    test_misaligned();
    test_wrap();
    test_contention();
    test_reset_mid_read();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
